// File: rtl/sd_mem_pkg.sv
// Shared definitions for the SD-preloaded memory: FSM encoding and word-sizing helpers.
package sd_mem_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GET   = 3'd1,
      FLUSH = 3'd2,
      FILL  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // Widest supported word filled with the pad byte; callers slice to DATA_WIDTH.
   function automatic logic [31:0] blank_word(input logic [7:0] pad);
      return {4{pad}};
   endfunction

endpackage

// File: rtl/sd_preload_mem_byte_packer.sv
// Packs a byte stream into DATA_WIDTH words in either byte order; pads a partial word on flush.
module byte_packer
   import sd_mem_pkg::*;
#(
   parameter int         DATA_WIDTH = 8,
   parameter bit         BIG_ENDIAN = 1'b0,
   parameter logic [7:0] BLANK      = 8'h2E
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_in,
   input  logic                  flush,
   output logic                  word_valid,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  lane_nz
);

   localparam int                    NB      = bytes_per_word(DATA_WIDTH);
   localparam int                    LW      = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [LW-1:0]         LAST    = LW'(NB - 1);
   localparam logic [31:0]           BLANK32 = blank_word(BLANK);
   localparam logic [DATA_WIDTH-1:0] BLANK_W = BLANK32[DATA_WIDTH-1:0];

   logic [LW-1:0]         lane_r;
   logic [DATA_WIDTH-1:0] pack_r;
   logic [DATA_WIDTH-1:0] merged;
   logic [LW-1:0]         pos;

   // Unfilled lanes of pack_r always hold BLANK, so a flush emits pack_r unchanged.
   always_comb begin
      merged = pack_r;
      if (BIG_ENDIAN) begin
         pos = LAST - lane_r;
      end else begin
         pos = lane_r;
      end
      merged[int'(pos)*8 +: 8] = byte_in;
   end

   assign lane_nz    = (lane_r != '0);
   assign word_valid = (byte_valid && (lane_r == LAST)) || (flush && lane_nz);
   assign word       = flush ? pack_r : merged;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_r <= '0;
         pack_r <= '0;
      end else if (clr) begin
         lane_r <= '0;
         pack_r <= BLANK_W;
      end else if (byte_valid) begin
         if (lane_r == LAST) begin
            lane_r <= '0;
            pack_r <= BLANK_W;
         end else begin
            lane_r <= lane_r + LW'(1);
            pack_r <= merged;
         end
      end else if (flush) begin
         lane_r <= '0;
         pack_r <= BLANK_W;
      end else begin
         lane_r <= lane_r;
         pack_r <= pack_r;
      end
   end

endmodule

// File: rtl/sd_preload_mem.sv
// Single-port memory image loaded from an SD reader byte stream, with optional CPU writes when idle.
module sd_preload_mem
   import sd_mem_pkg::*;
#(
   parameter int         DATA_WIDTH = 8,
   parameter int         ADDR_WIDTH = 14,
   parameter int         DEPTH      = 1 << ADDR_WIDTH,
   parameter int         LOAD_BASE  = 0,
   parameter logic [7:0] BLANK      = 8'h2E,
   parameter bit         BIG_ENDIAN = 1'b0,
   parameter bit         RAM_MODE   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic [DATA_WIDTH-1:0] DO,
   input  logic                  CS_N,
   input  logic                  OE_N,
   input  logic                  WE_N,
   input  logic                  ld_start,
   input  logic                  src_busy,
   input  logic                  src_outen,
   input  logic [7:0]            src_outbyte,
   input  logic                  src_done,
   input  logic                  src_err,
   output logic                  ldr_busy,
   output logic                  ldr_end,
   output logic                  ldr_err,
   output logic                  ldr_ovf,
   output logic [31:0]           file_size,
   output logic [7:0]            checksum
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   BASE_W  = (ADDR_WIDTH + 1)'(LOAD_BASE);
   localparam logic [31:0]           BLANK32 = blank_word(BLANK);
   localparam logic [DATA_WIDTH-1:0] BLANK_W = BLANK32[DATA_WIDTH-1:0];

   state_t state_r, next_state;
   logic [ADDR_WIDTH:0]   wp_r;
   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] do_r;
   logic                  busy_r, end_r, err_r, ovf_r;
   logic [31:0]           size_r;
   logic [7:0]            sum_r;
   logic                  room, start, accept, set_err, set_ovf, pk_flush, fill_we;
   logic                  pk_valid, pk_lane_nz, load_we, cpu_we;
   logic [DATA_WIDTH-1:0] pk_word, load_wd;

   assign room = (wp_r < DEPTH_W);

   byte_packer #(
      .DATA_WIDTH(DATA_WIDTH),
      .BIG_ENDIAN(BIG_ENDIAN),
      .BLANK     (BLANK)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clr       (start),
      .byte_valid(accept),
      .byte_in   (src_outbyte),
      .flush     (pk_flush),
      .word_valid(pk_valid),
      .word      (pk_word),
      .lane_nz   (pk_lane_nz)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state;
      end
   end

   // Error beats a simultaneous byte; a byte beats a simultaneous done.
   always_comb begin
      next_state = state_r;
      case (state_r)
         IDLE:    next_state = ld_start ? GET : IDLE;
         GET: begin
            if (src_err) begin
               next_state = DRAIN;
            end else if (src_outen && !room) begin
               next_state = DRAIN;
            end else if (src_done) begin
               next_state = FLUSH;
            end else begin
               next_state = GET;
            end
         end
         FLUSH:   next_state = FILL;
         FILL:    next_state = room ? FILL : IDLE;
         DRAIN:   next_state = src_busy ? DRAIN : IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      start    = 1'b0;
      accept   = 1'b0;
      set_err  = 1'b0;
      set_ovf  = 1'b0;
      pk_flush = 1'b0;
      fill_we  = 1'b0;
      case (state_r)
         IDLE:  start = ld_start;
         GET: begin
            if (src_err) begin
               set_err = 1'b1;
            end else if (src_outen) begin
               accept  = room;
               set_ovf = !room;
            end else begin
               accept = 1'b0;
            end
         end
         FLUSH: pk_flush = 1'b1;
         FILL:  fill_we = room;
         DRAIN: fill_we = 1'b0;
         default: fill_we = 1'b0;
      endcase
   end

   assign load_we = pk_valid || fill_we;
   assign load_wd = fill_we ? BLANK_W : pk_word;
   assign cpu_we  = RAM_MODE && !CS_N && !WE_N && !busy_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_r   <= '0;
         size_r <= 32'd0;
         sum_r  <= 8'd0;
         err_r  <= 1'b0;
         ovf_r  <= 1'b0;
         busy_r <= 1'b0;
         end_r  <= 1'b0;
      end else begin
         if (start) begin
            wp_r   <= BASE_W;
            size_r <= 32'd0;
            sum_r  <= 8'd0;
            err_r  <= 1'b0;
            ovf_r  <= 1'b0;
         end else begin
            wp_r   <= load_we ? wp_r + (ADDR_WIDTH + 1)'(1) : wp_r;
            size_r <= accept ? size_r + 32'd1 : size_r;
            sum_r  <= accept ? sum_r + src_outbyte : sum_r;
            err_r  <= err_r || set_err;
            ovf_r  <= ovf_r || set_ovf;
         end
         busy_r <= (next_state != IDLE);
         end_r  <= (state_r != IDLE) && (next_state == IDLE);
      end
   end

   // Memory contents survive reset, so the array and read register have no reset.
   always_ff @(posedge clk) begin
      if (load_we) begin
         mem[wp_r[ADDR_WIDTH-1:0]] <= load_wd;
      end else if (cpu_we) begin
         mem[A] <= DI;
      end else begin
         mem[A] <= mem[A];
      end
      do_r <= mem[A];
   end

   assign DO        = (!CS_N && !OE_N && !busy_r) ? do_r : {DATA_WIDTH{1'bz}};
   assign ldr_busy  = busy_r;
   assign ldr_end   = end_r;
   assign ldr_err   = err_r;
   assign ldr_ovf   = ovf_r;
   assign file_size = size_r;
   assign checksum  = sum_r;

endmodule

// File: tb/tb_sd_preload_mem.sv
// Directed bench for sd_preload_mem: 16-bit words, 8-word image, load base 2, both byte orders.
module tb_sd_preload_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  a = 3'd0;
   logic [15:0] di = 16'd0;
   logic        cs_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
   logic        ld_start = 1'b0, src_busy = 1'b0, src_outen = 1'b0, src_done = 1'b0, src_err = 1'b0;
   logic [7:0]  src_outbyte = 8'd0;
   wire  [15:0] do_le, do_be;
   logic        ldr_busy, ldr_end, ldr_err, ldr_ovf;
   logic [31:0] file_size;
   logic [7:0]  checksum;
   logic        be_busy, be_end, be_err, be_ovf;
   logic [31:0] be_size;
   logic [7:0]  be_sum;

   int n_tests = 0;
   int n_fail  = 0;
   int end_le  = 0;
   int end_be  = 0;
   int e0;
   logic [15:0] rle, rbe;
   logic [15:0] basic_le [8] = '{16'h1111, 16'h2222, 16'h0201, 16'h0403,
                                 16'h2E05, 16'h2E2E, 16'h2E2E, 16'h2E2E};

   always #5 clk = ~clk;

   sd_preload_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8), .LOAD_BASE(2),
                    .BLANK(8'h2E), .BIG_ENDIAN(1'b0), .RAM_MODE(1'b1)) dut (
      .clk(clk), .rst(rst), .A(a), .DI(di), .DO(do_le), .CS_N(cs_n), .OE_N(oe_n), .WE_N(we_n),
      .ld_start(ld_start), .src_busy(src_busy), .src_outen(src_outen), .src_outbyte(src_outbyte),
      .src_done(src_done), .src_err(src_err), .ldr_busy(ldr_busy), .ldr_end(ldr_end),
      .ldr_err(ldr_err), .ldr_ovf(ldr_ovf), .file_size(file_size), .checksum(checksum));

   sd_preload_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .DEPTH(8), .LOAD_BASE(2),
                    .BLANK(8'h2E), .BIG_ENDIAN(1'b1), .RAM_MODE(1'b0)) dut_be (
      .clk(clk), .rst(rst), .A(a), .DI(di), .DO(do_be), .CS_N(cs_n), .OE_N(oe_n), .WE_N(we_n),
      .ld_start(ld_start), .src_busy(src_busy), .src_outen(src_outen), .src_outbyte(src_outbyte),
      .src_done(src_done), .src_err(src_err), .ldr_busy(be_busy), .ldr_end(be_end),
      .ldr_err(be_err), .ldr_ovf(be_ovf), .file_size(be_size), .checksum(be_sum));

   always @(negedge clk) begin
      if (ldr_end) end_le <= end_le + 1;
      if (be_end)  end_be <= end_be + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      src_outen = 1'b1; src_outbyte = b; tick; src_outen = 1'b0;
   endtask

   task automatic start_load;
      ld_start = 1'b1; tick; ld_start = 1'b0;
   endtask

   task automatic finish_stream;
      src_done = 1'b1; tick; src_done = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (!ldr_busy && !be_busy) break;
         tick;
      end
      check(tag, {30'd0, ldr_busy, be_busy}, 32'd0);
   endtask

   task automatic rd(input logic [2:0] addr, output logic [15:0] le, output logic [15:0] be);
      a = addr; cs_n = 1'b0; oe_n = 1'b0; tick;
      le = do_le; be = do_be;
      cs_n = 1'b1; oe_n = 1'b1;
   endtask

   task automatic wr(input logic [2:0] addr, input logic [15:0] data);
      a = addr; di = data; cs_n = 1'b0; we_n = 1'b0; tick;
      we_n = 1'b1; cs_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      #3;
      check("rst_flags", {28'd0, ldr_busy, ldr_end, ldr_err, ldr_ovf}, 32'd0);
      check("rst_size", file_size, 32'd0);
      check("rst_sum", {24'd0, checksum}, 32'd0);
      #10 rst = 1'b0;
      tick;

      // Basic load, both byte orders
      wr(3'd0, 16'h1111);
      wr(3'd1, 16'h2222);
      e0 = end_le;
      start_load;
      check("busy_set", {31'd0, ldr_busy}, 32'd1);
      for (int i = 1; i <= 5; i++) send(8'(i));
      finish_stream;
      a = 3'd0; cs_n = 1'b0; oe_n = 1'b0; #1;
      check("do_hiz_busy", {31'd0, do_le !== 16'h1111}, 32'd1);
      cs_n = 1'b1; oe_n = 1'b1;
      wait_idle("basic_timeout");
      tick; tick; tick;
      check("basic_end_once", end_le - e0, 32'd1);
      check("basic_size", file_size, 32'd5);
      check("basic_sum", {24'd0, checksum}, 32'h0F);
      check("be_size", be_size, 32'd5);
      check("be_sum", {24'd0, be_sum}, 32'h0F);
      for (int i = 0; i < 8; i++) begin
         rd(3'(i), rle, rbe);
         check($sformatf("basic_mem%0d", i), {16'd0, rle}, {16'd0, basic_le[i]});
      end
      rd(3'd2, rle, rbe); check("be_mem2", {16'd0, rbe}, 32'h0102);
      rd(3'd3, rle, rbe); check("be_mem3", {16'd0, rbe}, 32'h0304);
      rd(3'd4, rle, rbe); check("be_mem4", {16'd0, rbe}, 32'h052E);

      // Overflow: 13 bytes into 6 free words, reader stays busy
      e0 = end_le;
      src_busy = 1'b1;
      start_load;
      for (int i = 0; i < 13; i++) send(8'(16 + i));
      tick; tick; tick;
      check("ovf_hold_busy", {31'd0, ldr_busy}, 32'd1);
      check("ovf_no_end_yet", end_le - e0, 32'd0);
      check("ovf_flag", {30'd0, ldr_ovf, be_ovf}, 32'd3);
      check("ovf_size", file_size, 32'd12);
      check("ovf_sum", {24'd0, checksum}, 32'h02);
      src_busy = 1'b0;
      wait_idle("ovf_timeout");
      tick; tick;
      check("ovf_end_once", end_le - e0, 32'd1);
      rd(3'd2, rle, rbe); check("ovf_mem2", {16'd0, rle}, 32'h1110);
      rd(3'd7, rle, rbe); check("ovf_mem7", {16'd0, rle}, 32'h1B1A);

      // Source error after three bytes
      src_busy = 1'b1;
      start_load;
      send(8'h21); send(8'h22); send(8'h23);
      src_err = 1'b1; tick; src_err = 1'b0;
      check("err_flag", {30'd0, ldr_err, be_err}, 32'd3);
      check("err_size", file_size, 32'd3);
      check("err_sum", {24'd0, checksum}, 32'h66);
      check("err_drain_busy", {31'd0, ldr_busy}, 32'd1);
      src_busy = 1'b0;
      wait_idle("err_timeout");
      rd(3'd2, rle, rbe); check("err_mem2", {16'd0, rle}, 32'h2221);
      rd(3'd3, rle, rbe); check("err_mem3_kept", {16'd0, rle}, 32'h1312);

      // RAM mode: write blocked during a load, accepted afterwards
      start_load;
      check("err_cleared", {31'd0, ldr_err}, 32'd0);
      wr(3'd1, 16'hABCD);
      finish_stream;
      wait_idle("ram_timeout");
      rd(3'd1, rle, rbe); check("ram_blocked", {16'd0, rle}, 32'h2222);
      rd(3'd5, rle, rbe); check("empty_fill", {16'd0, rle}, 32'h2E2E);
      wr(3'd1, 16'hABCD);
      rd(3'd1, rle, rbe); check("ram_write", {16'd0, rle}, 32'hABCD);

      // Reset in the middle of a load
      start_load;
      send(8'h01); send(8'h02);
      #2 rst = 1'b1;
      #1;
      check("midrst_flags", {28'd0, ldr_busy, ldr_end, ldr_err, ldr_ovf}, 32'd0);
      check("midrst_size", file_size, 32'd0);
      check("midrst_sum", {24'd0, checksum}, 32'd0);
      #2 rst = 1'b0;
      tick;
      start_load;
      for (int i = 1; i <= 5; i++) send(8'(i));
      finish_stream;
      wait_idle("reload_timeout");
      check("reload_size", file_size, 32'd5);
      check("reload_sum", {24'd0, checksum}, 32'h0F);
      rd(3'd2, rle, rbe); check("reload_mem2", {16'd0, rle}, 32'h0201);
      rd(3'd4, rle, rbe); check("reload_mem4", {16'd0, rle}, 32'h2E05);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_preload_mem.md
Name: sd_preload_mem

Overview:
- Parametrised successor of the SD-preloaded ROM: a single-port memory image filled from an external SD file-reader byte stream.
- Adds configurable data width with byte-to-word packing and selectable endianness.
- Adds a load base offset, a ROM or RAM mode (CPU writes allowed when idle), an overflow flag and a running byte checksum.
- Sits between the sd_file_reader instance and the 6502 bus. The SD reader is instantiated by the parent, not inside this block.

Parameters:
- DATA_WIDTH, 8, CPU word width; multiple of 8, range 8..32.
- ADDR_WIDTH, 14, CPU address width in words.
- DEPTH, 1<<ADDR_WIDTH, number of words.
- LOAD_BASE, 0, first word written by a load; must be less than DEPTH.
- BLANK, 8'h2E, pad byte for the partial last word and for unused words.
- BIG_ENDIAN, 0, 0 = first file byte goes to bits [7:0]; 1 = first byte goes to the MSB lane.
- RAM_MODE, 0, 0 = ROM (WE_N ignored); 1 = CPU writes allowed while not loading.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- A  in  ADDR_WIDTH  word address
- DI  in  DATA_WIDTH  write data (RAM_MODE only)
- DO  out  DATA_WIDTH  read data; high-Z unless enabled
- CS_N  in  1  chip select, active low
- OE_N  in  1  output enable, active low
- WE_N  in  1  write enable, active low
- ld_start  in  1  one-cycle load request
- src_busy  in  1  reader busy
- src_outen  in  1  byte valid strobe
- src_outbyte  in  8  file byte
- src_done  in  1  file completely read (pulse)
- src_err  in  1  reader error (level)
- ldr_busy  out  1  load in progress
- ldr_end  out  1  one-cycle completion pulse
- ldr_err  out  1  sticky source error
- ldr_ovf  out  1  sticky, file larger than DEPTH-LOAD_BASE words
- file_size  out  32  bytes accepted
- checksum  out  8  mod-256 sum of accepted bytes

Behaviour:
- **Reset (rst high, async):**
  - State goes to IDLE.
  - ldr_busy, ldr_end, ldr_err, ldr_ovf = 0; file_size = 0; checksum = 0; lane counter and pack register = 0.
  - Memory contents are not cleared.
- **Read path:**
  - DO_reg <= mem[A] every clk, giving 1-cycle latency.
  - DO = DO_reg when !CS_N && !OE_N && !ldr_busy, else 'z'.
- **Write path:** mem[A] <= DI when RAM_MODE && !CS_N && !WE_N && !ldr_busy. This is ignored during a load.
- **IDLE:**
  - ld_start: clear file_size, checksum, ldr_err, ldr_ovf, lane and word pointer (wp = LOAD_BASE); set ldr_busy; go to GET.
  - ld_start while busy is ignored.
- **GET:**
  - src_outen while wp < DEPTH: place the byte in the current lane, checksum += byte, file_size += 1.
    - If lane == DATA_WIDTH/8-1, write the packed word (including this byte) to mem[wp], wp += 1, lane = 0.
    - Otherwise lane += 1.
  - src_outen with wp == DEPTH: byte dropped, not counted, ldr_ovf = 1; go to DRAIN.
  - src_err: ldr_err = 1; go to DRAIN. If src_err and src_outen arrive together, the error wins and the byte is dropped.
  - src_done: go to FLUSH. If src_outen arrives in the same cycle, the byte is accepted first.
- **FLUSH:**
  - If lane != 0, write the pack register with unfilled lanes = BLANK to mem[wp], wp += 1.
  - Then go to FILL.
- **FILL:**
  - One word per clk: mem[wp] <= {BLANK replicated}, wp += 1 while wp < DEPTH.
  - At wp == DEPTH: clear ldr_busy, pulse ldr_end, go to IDLE.
  - Words below LOAD_BASE are preserved.
- **DRAIN:** wait for !src_busy, then clear ldr_busy, pulse ldr_end, go to IDLE. No fill is performed.
- **Width rules:**
  - wp has ADDR_WIDTH+1 bits.
  - file_size wraps at 2^32.
  - checksum wraps mod 256.
- **Reset mid-load:** immediate return to IDLE. The partially written image is retained and not flagged.

Decomposition:
- Package sd_mem_pkg:
  - state encoding constants IDLE/GET/FLUSH/FILL/DRAIN;
  - BYTES_PER_WORD function;
  - BLANK_WORD replicate helper.
- One natural sub-module, byte_packer:
  - holds the lane counter and pack register, handles endianness and pad-on-flush;
  - outputs word_valid/word.
- The FSM and memory array stay in the top module.

Test Plan (DATA_WIDTH=16, DEPTH=8, LOAD_BASE=2, BLANK=8'h2E, little-endian unless stated):
- **Basic load:** stream bytes 01..05 then src_done.
  - mem[2]=0201, mem[3]=0403, mem[4]=2E05, mem[5..7]=2E2E, mem[0..1] unchanged.
  - file_size=5, checksum=0F, exactly one ldr_end pulse, DO high-Z while busy.
- **Big-endian:** BIG_ENDIAN=1, same stream → mem[2]=0102, mem[4]=052E.
- **Overflow:** stream 13 bytes with src_busy held high.
  - Words 2..7 written, file_size=12, ldr_ovf=1.
  - ldr_end only after src_busy falls, no fill.
- **Error:** src_err after 3 bytes → ldr_err=1, file_size=3, DRAIN then ldr_end; a following ld_start clears ldr_err.
- **RAM mode:**
  - CPU write mem[1]=ABCD during a load is ignored.
  - After ldr_end the write succeeds; read of A=1 returns ABCD one cycle later.
- **Reset mid-load:** assert rst after 2 bytes → all status outputs 0 immediately; a new load then completes normally.
